// File: rtl/prince_sbox_cms_pipe.sv
// prince_sbox_cms_pipe -- first-order masked PRINCE S-box layer, consolidated
// masking style, two input shares in and two output shares out.
//
//   Stage 1: each S-box output bit is expanded into 16 non-complete cross-share
//            terms e_j. Each term is refreshed with a ring of fresh random bits
//            and registered.
//   Stage 2: the terms are compressed back to two shares. e_0..e_7 form share 0
//            and e_8..e_15 form share 1. The result is registered.
//
// Optional feature (macro PRINCE_SBOX_INV_EN): adds input in_inv. When in_inv
// is 1 the whole transaction uses the inverse S-box.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake; in_ready is combinational from out_ready
//   din_sh0, din_sh1     input shares; nibble k feeds S-box k
//   rnd                  fresh randomness, consumed only on accept
//   in_inv               (PRINCE_SBOX_INV_EN only) inverse-S-box select
//   out_valid/out_ready  output handshake
//   dout_sh0, dout_sh1   output shares; their XOR is S(din_sh0 ^ din_sh1)

// One S-box lane: purely combinational expansion and refresh.
module prince_sbox_cms_lane (
  input  logic             inv,
  input  logic [3:0]       a,    // share 0 nibble
  input  logic [3:0]       c,    // share 1 nibble
  input  logic [63:0]      r,    // 16 random bits per output bit
  output logic [3:0][15:0] e     // [out bit][term index j]
);
  // Nibble x of each table holds S(x).
  localparam logic [63:0] SBOX_FWD = 64'h4D5E087619CA23FB;
  localparam logic [63:0] SBOX_INV = 64'h1CE5046A98DF237B;

  // Moebius transform. Result bit [b][m] is the ANF coefficient of monomial m
  // in output bit b. It is evaluated at elaboration, so no table logic is built.
  function automatic logic [3:0][15:0] anf_of(input logic [63:0] tbl);
    logic [3:0][15:0] f;
    for (int b = 0; b < 4; b++) begin
      for (int x = 0; x < 16; x++) f[b][x] = tbl[4*x+b];
      for (int i = 0; i < 4; i++)
        for (int x = 0; x < 16; x++)
          if (x[i]) f[b][x] = f[b][x] ^ f[b][x ^ (1 << i)];
    end
    return f;
  endfunction

  localparam logic [3:0][15:0] ANF_FWD = anf_of(SBOX_FWD);
  localparam logic [3:0][15:0] ANF_INV = anf_of(SBOX_INV);

  // Each monomial m with share choice sigma lands in e_j, where j = sigma
  // restricted to m. So e_j collects every monomial m that is a superset of j,
  // using share 1 for the variables in j and share 0 for the rest.
  // The constant (m = 0, empty product = 1) falls into e_0.
  // e_j reads only c_i where j[i] = 1 and only a_i where j[i] = 0, which
  // keeps every term non-complete.
  // Refresh ring: r_j ^ r_{j+1} cancels across all 16 terms. Each half of
  // the ring keeps a residual mask of r_0 ^ r_8.
  function automatic logic [3:0][15:0] expand(input logic [3:0][15:0] anf,
                                              input logic [3:0] sa,
                                              input logic [3:0] sc,
                                              input logic [63:0] rr);
    logic [3:0][15:0] t;
    logic             p;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 16; j++) begin
        t[b][j] = rr[16*b+j] ^ rr[16*b+((j+1)%16)];
        for (int m = 0; m < 16; m++) begin
          if (anf[b][m] && ((j & ~m) == 0)) begin
            p = 1'b1;
            for (int i = 0; i < 4; i++)
              if (m[i]) p = p & (j[i] ? sc[i] : sa[i]);
            t[b][j] = t[b][j] ^ p;
          end
        end
      end
    end
    return t;
  endfunction

  always_comb begin
    e = expand(inv ? ANF_INV : ANF_FWD, a, c, r);
  end
endmodule

module prince_sbox_cms_pipe #(
  parameter  int N_SBOX = 16,
  localparam int W      = 4*N_SBOX,
  localparam int RND_W  = 64*N_SBOX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     din_sh0,
  input  logic [W-1:0]     din_sh1,
  input  logic [RND_W-1:0] rnd,
`ifdef PRINCE_SBOX_INV_EN
  input  logic             in_inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     dout_sh0,
  output logic [W-1:0]     dout_sh1
);
  localparam int STAGES = 2;

  logic [STAGES:1]               vld_pipe;   // [1] = v1, [2] = out_valid
  logic                          s2_adv, s1_adv, accept;
  logic                          inv_in;
  logic [N_SBOX-1:0][3:0][15:0]  e_nxt, e1;
  logic [W-1:0]                  cmp_sh0, cmp_sh1;

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid && s1_adv;
  assign out_valid = vld_pipe[2];

`ifdef PRINCE_SBOX_INV_EN
  logic inv1;         // mode of the transaction held in stage 1
  logic unused_mode;  // the mode is already folded into e1; kept for observability
  assign inv_in      = in_inv;
  assign unused_mode = inv1;
  always_ff @(posedge clk) begin
    if (rst)         inv1 <= 1'b0;
    else if (accept) inv1 <= in_inv;
  end
`else
  assign inv_in = 1'b0;
`endif

  for (genvar k = 0; k < N_SBOX; k++) begin : g_lane
    prince_sbox_cms_lane u_lane (
      .inv (inv_in),
      .a   (din_sh0[4*k +: 4]),
      .c   (din_sh1[4*k +: 4]),
      .r   (rnd[64*k +: 64]),
      .e   (e_nxt[k])
    );
    for (genvar b = 0; b < 4; b++) begin : g_bit
      assign cmp_sh0[4*k+b] = ^e1[k][b][7:0];
      assign cmp_sh1[4*k+b] = ^e1[k][b][15:8];
    end
  end

  // Stage-1 data moves only on accept, so idle cycles never load glitchy
  // terms built from unaccepted inputs or randomness.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      e1       <= '0;
      dout_sh0 <= '0;
      dout_sh1 <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= in_valid;
      if (accept) e1 <= e_nxt;
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          dout_sh0 <= cmp_sh0;
          dout_sh1 <= cmp_sh1;
        end
      end
    end
  end
endmodule

// File: tb/tb_prince_sbox_cms_pipe.sv
// Self-checking bench for prince_sbox_cms_pipe. Expected results come from
// plain S-box table lookups on the unmasked value din_sh0 ^ din_sh1.
module tb_prince_sbox_cms_pipe;
  localparam int N     = 16;
  localparam int W     = 4*N;
  localparam int RND_W = 64*N;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]     din_sh0, din_sh1, dout_sh0, dout_sh1;
  logic [RND_W-1:0] rnd;
`ifdef PRINCE_SBOX_INV_EN
  logic             in_inv = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [3:0] SFWD [16] = '{4'hB,4'hF,4'h3,4'h2,4'hA,4'hC,4'h9,4'h1,
                            4'h6,4'h7,4'h8,4'h0,4'hE,4'h5,4'hD,4'h4};
  logic [3:0] SINV [16] = '{4'hB,4'h7,4'h3,4'h2,4'hF,4'hD,4'h8,4'h9,
                            4'hA,4'h6,4'h4,4'h0,4'h5,4'hE,4'hC,4'h1};

  prince_sbox_cms_pipe #(.N_SBOX(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din_sh0(din_sh0), .din_sh1(din_sh1), .rnd(rnd),
`ifdef PRINCE_SBOX_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .dout_sh0(dout_sh0), .dout_sh1(dout_sh1)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_sbox(input logic [W-1:0] x, input bit inv);
    logic [W-1:0] y;
    logic [3:0]   nib;
    for (int k = 0; k < N; k++) begin
      nib = x[4*k +: 4];
      y[4*k +: 4] = inv ? SINV[nib] : SFWD[nib];
    end
    return y;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  task automatic rand_rnd();
    for (int i = 0; i < RND_W/32; i++) rnd[32*i +: 32] = $urandom();
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sh0_zero;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    din_sh0 = '0; din_sh1 = '0; rnd = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (dout_sh0 !== '0) begin bad++; $display("FAIL reset_dout_sh0 got=%h exp=0", dout_sh0); end
    total++; if (dout_sh1 !== '0) begin bad++; $display("FAIL reset_dout_sh1 got=%h exp=0", dout_sh1); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_out_valid got=%b exp=0", out_valid); end
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] x;
    x = '0; x[3:0] = 4'h5;
    din_sh0 = x; din_sh1 = '0; rnd = '0; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_latency1 got=%b exp=0", out_valid); end
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency2 got=%b exp=1", out_valid); end
    total++; if ((dout_sh0 ^ dout_sh1) !== ref_sbox(x, 1'b0)) begin
      bad++; $display("FAIL basic_xor got=%h exp=%h", dout_sh0 ^ dout_sh1, ref_sbox(x, 1'b0)); end
    total++; if ((dout_sh0[3:0] ^ dout_sh1[3:0]) !== 4'hC) begin
      bad++; $display("FAIL basic_nib0 got=%h exp=c", dout_sh0[3:0] ^ dout_sh1[3:0]); end
    sh0_zero = dout_sh0;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_single got=%b exp=0", out_valid); end
  endtask

  task automatic test_sweep();
    logic [W-1:0] q [$];
    logic [W-1:0] x, s1, e;
    out_ready = 1'b1;
    for (int c = 0; c < 258; c++) begin
      if (c < 256) begin
        x = rand_w(); x[3:0] = c[7:4];
        s1 = rand_w(); s1[3:0] = c[3:0];
        din_sh1 = s1; din_sh0 = x ^ s1; in_valid = 1'b1;
        rand_rnd();
        q.push_back(ref_sbox(x, 1'b0));
      end else in_valid = 1'b0;
      #1;
      if (c < 256) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sweep_in_ready c=%0d got=%b exp=1", c, in_ready); end
      end
      if (c >= 2) begin
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL sweep_rate c=%0d got=%b exp=1", c, out_valid); end
        else if (q.size() == 0) begin bad++; $display("FAIL sweep_extra c=%0d got=1 exp=0", c); end
        else begin
          e = q.pop_front();
          if ((dout_sh0 ^ dout_sh1) !== e) begin
            bad++; $display("FAIL sweep_xor c=%0d got=%h exp=%h", c, dout_sh0 ^ dout_sh1, e); end
        end
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sweep_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_rnd_mask();
    logic [W-1:0]     x, ref0, ref1, held0, held1, ta, tb, sa;
    logic [RND_W-1:0] saved;
    x = '0; x[3:0] = 4'h5;
    out_ready = 1'b1;
    din_sh0 = x; din_sh1 = '0; rand_rnd(); saved = rnd; in_valid = 1'b1;
    step();
    in_valid = 1'b0; rand_rnd();
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mask_valid got=%b exp=1", out_valid); end
    total++; if (dout_sh0 === sh0_zero) begin bad++; $display("FAIL mask_differs got=%h exp=not %h", dout_sh0, sh0_zero); end
    total++; if ((dout_sh0 ^ dout_sh1) !== ref_sbox(x, 1'b0)) begin
      bad++; $display("FAIL mask_xor got=%h exp=%h", dout_sh0 ^ dout_sh1, ref_sbox(x, 1'b0)); end
    ref0 = dout_sh0; ref1 = dout_sh1;
    step();
    // Fill the pipe with two transactions while the output is blocked.
    out_ready = 1'b0;
    ta = rand_w(); sa = rand_w();
    din_sh0 = ta ^ sa; din_sh1 = sa; in_valid = 1'b1; rand_rnd();
    step();
    tb = rand_w(); sa = rand_w();
    din_sh0 = tb ^ sa; din_sh1 = sa; rand_rnd();
    step();
    // Offer the reference input with throwaway randomness while stalled.
    din_sh0 = x; din_sh1 = '0;
    held0 = dout_sh0; held1 = dout_sh1;
    for (int c = 0; c < 3; c++) begin
      rand_rnd();
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, in_ready); end
      total++; if (out_valid !== 1'b1 || dout_sh0 !== held0 || dout_sh1 !== held1) begin
        bad++; $display("FAIL stall_hold c=%0d got=%b/%h/%h exp=1/%h/%h", c, out_valid, dout_sh0, dout_sh1, held0, held1); end
      step();
    end
    total++; if ((held0 ^ held1) !== ref_sbox(ta, 1'b0)) begin
      bad++; $display("FAIL stall_ta got=%h exp=%h", held0 ^ held1, ref_sbox(ta, 1'b0)); end
    out_ready = 1'b1; rnd = saved;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0; rand_rnd();
    #1;
    total++; if (out_valid !== 1'b1 || (dout_sh0 ^ dout_sh1) !== ref_sbox(tb, 1'b0)) begin
      bad++; $display("FAIL release_tb got=%b/%h exp=1/%h", out_valid, dout_sh0 ^ dout_sh1, ref_sbox(tb, 1'b0)); end
    step();
    total++; if (out_valid !== 1'b1 || dout_sh0 !== ref0 || dout_sh1 !== ref1) begin
      bad++; $display("FAIL rnd_ignored got=%h/%h exp=%h/%h", dout_sh0, dout_sh1, ref0, ref1); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mask_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] xs [3];
    logic [W-1:0] ms [3];
    logic [W-1:0] q [$];
    logic [W-1:0] held0, held1, e;
    int  idx, got;
    bit  acc, have;
    for (int i = 0; i < 3; i++) begin xs[i] = rand_w(); ms[i] = rand_w(); end
    idx = 0; got = 0; have = 1'b0; held0 = '0; held1 = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin din_sh1 = ms[idx]; din_sh0 = xs[idx] ^ ms[idx]; end
      rand_rnd();
      #1;
      acc = in_valid && in_ready;
      if (acc) q.push_back(ref_sbox(xs[idx], 1'b0));
      if (out_valid) begin
        if (!have) begin held0 = dout_sh0; held1 = dout_sh1; have = 1'b1; end
        else begin
          total++; if (dout_sh0 !== held0 || dout_sh1 !== held1) begin
            bad++; $display("FAIL bp_hold c=%0d got=%h/%h exp=%h/%h", c, dout_sh0, dout_sh1, held0, held1); end
        end
      end
      step();
      if (acc) idx++;
    end
    #1;
    total++; if (idx !== 2) begin bad++; $display("FAIL bp_accepts got=%0d exp=2", idx); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin din_sh1 = ms[idx]; din_sh0 = xs[idx] ^ ms[idx]; end
      rand_rnd();
      #1;
      acc = in_valid && in_ready;
      if (acc) q.push_back(ref_sbox(xs[idx], 1'b0));
      if (out_valid) begin
        got++;
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL bp_dup c=%0d got=extra exp=none", c); end
        else begin
          e = q.pop_front();
          if ((dout_sh0 ^ dout_sh1) !== e) begin
            bad++; $display("FAIL bp_order c=%0d got=%h exp=%h", c, dout_sh0 ^ dout_sh1, e); end
        end
      end
      step();
      if (acc) idx++;
    end
    total++; if (got !== 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", got); end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] m;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m = rand_w(); din_sh1 = m; din_sh0 = rand_w(); in_valid = 1'b1; rand_rnd();
      step();
    end
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_inflight got=%b exp=1", out_valid); end
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || dout_sh0 !== '0 || dout_sh1 !== '0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%h exp=0/0/0", out_valid, dout_sh0, dout_sh1); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale c=%0d got=%b exp=0", c, out_valid); end
    end
  endtask

`ifdef PRINCE_SBOX_INV_EN
  task automatic test_inverse();
    logic [W-1:0] q [$];
    logic [W-1:0] x, s1, e;
    out_ready = 1'b1;
    for (int c = 0; c < 34; c++) begin
      if (c < 32) begin
        x = rand_w();
        if (c == 1) begin x[3:0] = 4'h0; x[7:4] = 4'h4; end
        s1 = rand_w();
        din_sh1 = s1; din_sh0 = x ^ s1; in_valid = 1'b1; in_inv = c[0];
        rand_rnd();
        q.push_back(ref_sbox(x, c[0]));
      end else in_valid = 1'b0;
      #1;
      if (c >= 2) begin
        total++;
        if (out_valid !== 1'b1 || q.size() == 0) begin bad++; $display("FAIL inv_rate c=%0d got=%b exp=1", c, out_valid); end
        else begin
          e = q.pop_front();
          if ((dout_sh0 ^ dout_sh1) !== e) begin
            bad++; $display("FAIL inv_xor c=%0d got=%h exp=%h", c, dout_sh0 ^ dout_sh1, e); end
        end
      end
      step();
    end
    in_inv = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_rnd_mask();
    test_backpressure();
    test_reset_midflight();
`ifdef PRINCE_SBOX_INV_EN
    test_inverse();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
